// File: rtl/load_store_unit.sv
// RV32I load/store unit: word-wide memory cycles, byte-lane extraction/extension, sub-word stores via read-modify-write.
// Optional macro LSU_MISALIGN_ERR_EN: misaligned half/word requests error out instead of being truncated to alignment.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Handshake: a request transfers on a rising edge where req_valid & req_ready;
    // req_ready is high only in IDLE. resp_valid is a one-cycle pulse with no backpressure.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD     = 3'd1,
        S_ST     = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rmw_q;

    logic              f3_illegal;
    logic              misalign;
    logic              req_err;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_ext;
    logic [DATA_W-1:0] st_word;
    logic              mem_wr_en;

    always_comb begin
        if (req_we)
            f3_illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        else
            f3_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_ERR_EN
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        req_err = f3_illegal || misalign;
    end

    // Half lane comes from addr[1] only, so an unaligned half is truncated when errors are off.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        st_word = rmw_q;
        if (f3_q[1:0] == 2'b00)
            st_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            st_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_wr_en  = 1'b0;
        mem_wdata  = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)
                        state_d = S_RESP;
                    else if (!req_we)
                        state_d = S_LD;
                    else if (req_funct3 == 3'b010)
                        state_d = S_ST;
                    else
                        state_d = S_RMW_RD;
                end
            end
            S_LD: begin
                mem_read = 1'b1;
                state_d  = S_RESP;
            end
            S_ST: begin
                mem_wr_en = 1'b1;
                mem_wdata = wdata_q;
                state_d   = S_RESP;
            end
            S_RMW_RD: begin
                mem_read = 1'b1;
                state_d  = S_RMW_WR;
            end
            S_RMW_WR: begin
                mem_wr_en = 1'b1;
                mem_wdata = st_word;
                state_d   = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Gating by rst keeps a reset that lands in RMW_WR from committing a half-built word.
    assign mem_write = mem_wr_en && !rst;
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};

    // Response registers load on the edge that enters RESP, then hold until the next response.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            rmw_q      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                S_LD: begin
                    resp_rdata <= ld_ext;
                    resp_err   <= 1'b0;
                end
                S_RMW_RD: rmw_q <= mem_rdata;
                S_ST, S_RMW_WR: begin
                    resp_rdata <= '0;
                    resp_err   <= we_q ? 1'b0 : 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
